// File: rtl/logic_exec_pkg.sv
// Shared types and default widths for the bitwise logic execute pipe.
package logic_exec_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int TAG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_ANDN = 2'd3
  } logic_op_e;

endpackage

// File: rtl/and_32bit.sv
// Bitwise AND of two words; purely combinational, no backpressure.
module and_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/logic_unit_32bit.sv
// Bitwise logic unit: AND / OR / XOR / ANDN selected by op.
// Combinational, zero latency, no backpressure.
module logic_unit_32bit
  import logic_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic_op_e        op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o
);

  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] andn_res;
  logic [WIDTH-1:0] b_inv;

  assign b_inv = ~b_i;

  and_32bit #(.WIDTH(WIDTH)) u_and (
    .a_i (a_i),
    .b_i (b_i),
    .y_o (and_res)
  );

  // ANDN reuses the AND cell with operand B pre-inverted
  and_32bit #(.WIDTH(WIDTH)) u_andn (
    .a_i (a_i),
    .b_i (b_inv),
    .y_o (andn_res)
  );

  always_comb begin
    c_o = '0;
    unique case (op_i)
      OP_AND:  c_o = and_res;
      OP_OR:   c_o = a_i | b_i;
      OP_XOR:  c_o = a_i ^ b_i;
      OP_ANDN: c_o = andn_res;
      default: c_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_exec_pipe.sv
// Two-stage execute wrapper around the logic unit; 2-cycle latency, 1 op/cycle.
// Full valid/ready backpressure: in_ready_o depends only on stage state and out_ready_i.
module logic_exec_pipe
  import logic_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] c_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  logic             v1_q, v2_q;
  logic_op_e        op1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [WIDTH-1:0] c2_q;
  logic [TAG_W-1:0] tag2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lu_res;

  logic adv1, adv2, in_fire, out_fire;

  assign adv2     = !v2_q | out_ready_i;
  assign adv1     = !v1_q | adv2;
  assign in_fire  = in_valid_i & adv1;
  assign out_fire = v2_q & out_ready_i;

  assign cnt_d = out_fire ? cnt_q + CNT_W'(1) : cnt_q;

  logic_unit_32bit #(.WIDTH(WIDTH)) u_lu (
    .op_i (op1_q),
    .a_i  (a1_q),
    .b_i  (b1_q),
    .c_o  (lu_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      op1_q  <= OP_AND;
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
      c2_q   <= '0;
      tag2_q <= '0;
      cnt_q  <= '0;
    end else begin
      // A result leaving during a flush has been taken downstream, so it still counts
      cnt_q <= cnt_d;
      if (flush_i) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
      end else begin
        if (adv2) begin
          v2_q <= v1_q;
          if (v1_q) begin
            c2_q   <= lu_res;
            tag2_q <= tag1_q;
          end
        end
        if (adv1) begin
          v1_q <= in_fire;
          if (in_fire) begin
            op1_q  <= logic_op_e'(op_i);
            a1_q   <= a_i;
            b1_q   <= b_i;
            tag1_q <= tag_i;
          end
        end
      end
    end
  end

  assign in_ready_o  = adv1;
  assign out_valid_o = v2_q;
  assign c_o         = c2_q;
  assign tag_o       = tag2_q;
  assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_logic_exec_pipe.sv
// Directed bench for logic_exec_pipe with a transaction scoreboard for results.
module tb_logic_exec_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic [4:0]  tag_out;
  logic [15:0] done_cnt;

  typedef struct packed {
    logic [31:0] c;
    logic [4:0]  tag;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;

  logic_exec_pipe dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c),
    .tag_o       (tag_out),
    .done_cnt_o  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return x & ~y;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Score the handshakes that will happen at the coming edge, then advance.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        chk("spurious_result", 64'(c), 64'hDEAD);
      end else begin
        e = expq.pop_front();
        chk("result_c", 64'(c), 64'(e.c));
        chk("result_tag", 64'(tag_out), 64'(e.tag));
      end
    end
    if (flush) expq.delete();
    else if (in_valid && in_ready) expq.push_back({golden(op, a, b), tag});
    step();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    expq.delete();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    in_valid = 1'b1;
    op = o; a = x; b = y; tag = t;
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int i = 0; i < budget && (expq.size() != 0 || out_valid); i++) tick();
    chk("drain_left", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; a = '0; b = '0; tag = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    #1;

    // Single AND op: valid presented, accepted at the next edge, visible one edge after
    out_ready = 1'b1;
    drive(2'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3);
    step();
    in_valid = 1'b0;
    chk("single_lat1_valid", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_c", 64'(c), 64'h00F0_1234);
    chk("single_tag", 64'(tag_out), 64'd3);
    step();
    chk("single_done", 64'(done_cnt), 64'd1);
    chk("single_gone", 64'(out_valid), 64'd0);

    // Streaming 100 random ops at full rate
    do_reset();
    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(2'($urandom_range(3, 0)), $urandom, $urandom, 5'($urandom_range(31, 0)));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    drain(10);
    chk("stream_count", 64'(n_out), 64'd100);
    chk("stream_done", 64'(done_cnt), 64'd100);

    // Backpressure: two accepts fill the pipe, third op is held
    do_reset();
    out_ready = 1'b0;
    drive(2'd1, 32'h1111_0000, 32'h0000_2222, 5'd10);
    tick();
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    drive(2'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd11);
    tick();
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    drive(2'd3, 32'hAAAA_5555, 32'h00FF_00FF, 5'd12);
    tick();
    tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_head_valid", 64'(out_valid), 64'd1);
    chk("bp_head_c", 64'(c), 64'h1111_2222);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 64'(in_ready), 64'd1);
    n_out = 0;
    tick();
    drain(10);
    chk("bp_count", 64'(n_out), 64'd3);
    chk("bp_done", 64'(done_cnt), 64'd3);

    // Flush with the output stalled: nothing counted, new op dropped
    do_reset();
    out_ready = 1'b0;
    drive(2'd0, 32'h1234_5678, 32'hFFFF_0000, 5'd1); tick();
    drive(2'd1, 32'h0000_00F0, 32'h0000_000F, 5'd2); tick();
    flush = 1'b1;
    drive(2'd2, 32'hCAFE_0000, 32'h0000_BEEF, 5'd4);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_done", 64'(done_cnt), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // Flush while draining: the departing result still counts, incoming op is dropped
    out_ready = 1'b0;
    drive(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5); tick();
    drive(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6); tick();
    out_ready = 1'b1;
    flush = 1'b1;
    drive(2'd1, 32'h0000_0003, 32'h0000_0004, 5'd7);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_done", 64'(done_cnt), 64'd1);
    tick(); tick();
    chk("flush2_dropped", 64'(out_valid), 64'd0);
    chk("flush2_done_hold", 64'(done_cnt), 64'd1);

    // Asynchronous reset with both stages full, asserted between edges
    out_ready = 1'b0;
    drive(2'd2, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd8); tick();
    drive(2'd3, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd9); tick();
    in_valid = 1'b0;
    chk("arst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_done", 64'(done_cnt), 64'd0);
    #1;
    rst_n = 1'b1;
    expq.delete();
    #1;
    chk("arst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("arst_discarded", 64'(out_valid), 64'd0);

    // Counter wrap: continuous stream, first completion at the third edge
    do_reset();
    out_ready = 1'b1;
    drive(2'd0, 32'h1, 32'h1, 5'd0);
    repeat (65537) step();
    chk("wrap_max", 64'(done_cnt), 64'hFFFF);
    step();
    chk("wrap_zero", 64'(done_cnt), 64'd0);
    step();
    chk("wrap_one", 64'(done_cnt), 64'd1);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
